// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box definitions: mode encoding, engine state encoding and
// the forward / inverse substitution tables.
package aes_sbox_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX_FWD_TBL [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV_TBL [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD_TBL[b];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV_TBL[b];
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane carrying both the forward and inverse table.
module sbox_lane
  import aes_sbox_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       mode,
  output logic [7:0] byte_out
);

  // Table select by mode.
  always_comb begin
    byte_out = (mode == MODE_INV) ? sbox_inv(byte_in) : sbox_fwd(byte_in);
  end

endmodule

// File: rtl/sbox_sub_engine.sv
// Time-multiplexed SubBytes / InvSubBytes engine: one word in, LANES bytes
// substituted per cycle in place in the work register, result handed out
// over valid/ready with same-edge retire-and-accept.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for a word, in_ready high
//   ST_RUN  | substituting lane group cnt_q of the work register
//   ST_DONE | result on out_data, waiting for out_ready (may accept next)
module sbox_sub_engine
  import aes_sbox_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 16,
  parameter int unsigned LANES      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [8*WORD_BYTES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*WORD_BYTES-1:0] out_data,
  output logic                    busy
);

  localparam int unsigned BEATS = WORD_BYTES / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  if ((WORD_BYTES % LANES) != 0) begin : g_bad_lanes
    $error("sbox_sub_engine: LANES must divide WORD_BYTES");
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [8*WORD_BYTES-1:0] work_q, work_d;
  logic                    mode_q, mode_d;
  logic [7:0]              lane_in  [LANES];
  logic [7:0]              lane_out [LANES];

  // Lane inputs: the byte group of the work register selected by the beat counter.
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      lane_in[l] = work_q[(int'(cnt_q) * int'(LANES) + l) * 8 +: 8];
    end
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    sbox_lane u_lane (
      .byte_in  (lane_in[g]),
      .mode     (mode_q),
      .byte_out (lane_out[g])
    );
  end

  assign in_ready  = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = work_q;

  // Next state, beat counter and in-place byte substitution.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          mode_d  = in_mode;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int l = 0; l < int'(LANES); l++) begin
          work_d[(int'(cnt_q) * int'(LANES) + l) * 8 +: 8] = lane_out[l];
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            // Retire and accept on the same edge so no IDLE bubble is inserted.
            work_d  = in_data;
            mode_d  = in_mode;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, work and mode registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      mode_q  <= MODE_FWD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_sbox_sub_engine.sv
// Bench for sbox_sub_engine: S-box reference computed from GF(2^8) inverse
// plus affine map, a cycle model of the handshake, directed scenarios, and a
// second instance with LANES = WORD_BYTES.
module tb_sbox_sub_engine;

  localparam int WB    = 16;
  localparam int LN    = 4;
  localparam int BEATS = WB / LN;

  localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;
  localparam logic [127:0] ALL_63   = {16{8'h63}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;

  logic         in_valid16 = 1'b0, in_mode16 = 1'b0, out_ready16 = 1'b1;
  logic [127:0] in_data16 = '0;
  logic         in_ready16, out_valid16, busy16;
  logic [127:0] out_data16;

  int checks = 0;
  int errors = 0;

  logic [7:0] t_fwd [256];
  logic [7:0] t_inv [256];

  always #5 clk = ~clk;

  sbox_sub_engine #(.WORD_BYTES(WB), .LANES(LN)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  sbox_sub_engine #(.WORD_BYTES(WB), .LANES(WB)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_mode(in_mode16), .in_data(in_data16), .out_valid(out_valid16),
    .out_ready(out_ready16), .out_data(out_data16), .busy(busy16)
  );

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_word(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gf_mul(v, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_word(input logic [127:0] d, input logic m);
    logic [127:0] r;
    for (int i = 0; i < WB; i++) begin
      r[8*i +: 8] = m ? t_inv[d[8*i +: 8]] : t_fwd[d[8*i +: 8]];
    end
    return r;
  endfunction

  // Cycle model: check outputs at each falling edge, then advance to the next rising edge.
  logic         m_busy = 1'b0, m_valid = 1'b0, m_known = 1'b1;
  int           m_cnt = 0;
  logic [127:0] m_exp = '0, m_out = '0;

  initial begin
    forever begin
      @(negedge clk);
      chk_bit("model_in_ready", in_ready, rst_n && (!m_busy || (m_valid && out_ready)));
      chk_bit("model_out_valid", out_valid, m_valid);
      chk_bit("model_busy", busy, m_busy);
      if (m_known) chk_word("model_out_data", out_data, m_out);
      if (!rst_n) begin
        m_busy = 1'b0; m_valid = 1'b0; m_known = 1'b1; m_out = '0; m_cnt = 0;
      end else if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1; m_cnt = BEATS; m_exp = sub_word(in_data, in_mode); m_known = 1'b0;
        end
      end else if (!m_valid) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1'b1; m_out = m_exp; m_known = 1'b1;
        end
      end else if (out_ready) begin
        m_valid = 1'b0;
        if (in_valid) begin
          m_cnt = BEATS; m_exp = sub_word(in_data, in_mode); m_known = 1'b0;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic m);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready never rose t=%0t", $time);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_mode  = ~m;
  endtask

  // Edges after the accept edge until out_valid is seen (-1 if never).
  task automatic latency(output int lat);
    lat = -1;
    for (int n = 1; n <= 12 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = n;
    end
  endtask

  task automatic wait_retire(input bit rand_stall);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 64 && !done; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        out_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          @(posedge clk);
          #1;
          done = 1'b1;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout word never retired t=%0t", $time);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [127:0] w;

    for (int i = 0; i < 256; i++) t_fwd[i] = ref_sbox(8'(i));
    for (int i = 0; i < 256; i++) t_inv[t_fwd[i]] = 8'(i);

    // Reference model pinned to literal table values.
    chk_word("ref_fwd_00", {120'b0, t_fwd[8'h00]}, 128'h63);
    chk_word("ref_fwd_53", {120'b0, t_fwd[8'h53]}, 128'hed);
    chk_word("ref_inv_63", {120'b0, t_inv[8'h63]}, 128'h00);
    chk_word("ref_inv_52", {120'b0, t_inv[8'h52]}, 128'h48);
    chk_word("ref_inv_ff", {120'b0, t_inv[8'hff]}, 128'h7d);
    chk_word("ref_fips_word", sub_word(FIPS_IN, 1'b0), FIPS_OUT);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_bit("rst_in_ready", in_ready, 1'b0);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_word("rst_out_data", out_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LANES = WORD_BYTES instance: single-beat latency.
    in_data16 = FIPS_IN; in_mode16 = 1'b0; in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(negedge clk);
    chk_bit("l16_in_ready", in_ready16, 1'b1);
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    chk_bit("l16_run_valid", out_valid16, 1'b0);
    chk_bit("l16_run_busy", busy16, 1'b1);
    @(posedge clk);
    #1;
    chk_bit("l16_out_valid", out_valid16, 1'b1);
    chk_word("l16_out_data", out_data16, FIPS_OUT);
    @(posedge clk);
    #1;
    chk_bit("l16_retired", out_valid16, 1'b0);

    // Forward FIPS-197 vector.
    out_ready = 1'b1;
    send(FIPS_IN, 1'b0);
    latency(lat);
    chk_int("fips_fwd_latency", lat, BEATS);
    chk_word("fips_fwd_data", out_data, FIPS_OUT);
    @(posedge clk);
    #1;

    // Inverse round trip.
    send(FIPS_OUT, 1'b1);
    latency(lat);
    chk_int("fips_inv_latency", lat, BEATS);
    chk_word("fips_inv_data", out_data, FIPS_IN);
    @(posedge clk);
    #1;

    // Backpressure for 10 cycles.
    out_ready = 1'b0;
    send(FIPS_IN, 1'b0);
    latency(lat);
    chk_int("bp_latency", lat, BEATS);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk_bit("bp_out_valid", out_valid, 1'b1);
      chk_word("bp_out_data", out_data, FIPS_OUT);
      chk_bit("bp_in_ready", in_ready, 1'b0);
      chk_bit("bp_busy", busy, 1'b1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_bit("bp_release_valid", out_valid, 1'b0);
    chk_bit("bp_release_idle", busy, 1'b0);

    // Bypass: retire and accept all-zero word on the same edge.
    out_ready = 1'b0;
    send(FIPS_OUT, 1'b1);
    latency(lat);
    chk_int("byp_first_latency", lat, BEATS);
    in_data = '0; in_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_bit("byp_retired", out_valid, 1'b0);
    chk_bit("byp_no_idle", busy, 1'b1);
    latency(lat);
    chk_int("byp_second_latency", lat, BEATS);
    chk_word("byp_second_data", out_data, ALL_63);
    @(posedge clk);
    #1;

    // Reset during RUN discards the word.
    send(FIPS_IN, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_bit("rstrun_out_valid", out_valid, 1'b0);
    chk_word("rstrun_out_data", out_data, '0);
    @(negedge clk);
    chk_bit("rstrun_in_ready", in_ready, 1'b1);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk_bit("rstrun_no_valid", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Full table sweep in both directions with random output stalls.
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < 16; j++) begin
        for (int i = 0; i < WB; i++) w[8*i +: 8] = 8'(16 * j + i);
        send(w, 1'(m));
        wait_retire(1'b1);
      end
    end

    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
